// File: rtl/vend_pkg.sv
// vend_pkg: shared states, error codes and coin constants for the vending controller
package vend_pkg;
  typedef enum logic [1:0] {ST_SELECT, ST_VEND, ST_CHANGE, ST_CLEAR} state_e;
  typedef enum logic [1:0] {ERR_NONE, ERR_NOSEL, ERR_FUNDS, ERR_DESEL} err_e;
  localparam logic [7:0] NICKEL  = 8'd5;
  localparam logic [7:0] DIME    = 8'd10;
  localparam logic [7:0] QUARTER = 8'd25;
  localparam logic [7:0] BCD_SAT = 8'h99;
endpackage

// File: rtl/vend_bin2bcd.sv
// vend_bin2bcd: 8-bit binary to two-digit BCD, saturating at 99
module vend_bin2bcd
  import vend_pkg::*;
(
  input  logic [7:0] bin_i,
  output logic [7:0] bcd_o
);
  assign bcd_o = (bin_i > 8'd99) ? BCD_SAT : {4'(bin_i / 8'd10), 4'(bin_i % 8'd10)};
endmodule

// File: rtl/vend_ctrl_param.sv
// vend_ctrl_param: parametrised vending controller with paced change return; COMBO_DISCOUNT_EN enables the combo discount
module vend_ctrl_param
  import vend_pkg::*;
#(
  parameter int                          N_ITEMS        = 4,
  parameter int                          PRICE_W        = 7,
  parameter logic [N_ITEMS*PRICE_W-1:0]  PRICES         = {7'd80, 7'd65, 7'd50, 7'd25},
  parameter int                          MAX_CREDIT     = 95,
  parameter int                          VEND_CYCLES    = 8,
  parameter int                          CHANGE_GAP     = 4,
  parameter logic [N_ITEMS-1:0]          COMBO_MASK     = 4'b0101,
  parameter int                          COMBO_DISCOUNT = 10
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_nickel,
  input  logic               i_dime,
  input  logic               i_quarter,
  input  logic [N_ITEMS-1:0] i_sel,
  input  logic               i_buy,
  input  logic               i_cancel,
  output logic [N_ITEMS-1:0] o_vend,
  output logic               o_coin_n,
  output logic               o_coin_d,
  output logic               o_coin_q,
  output logic               o_coin_reject,
  output logic               o_error,
  output logic [1:0]         o_err_code,
  output logic [7:0]         o_cost_bcd,
  output logic [7:0]         o_credit_bcd,
  output logic [1:0]         o_state,
  output logic               o_discount
);
`ifdef COMBO_DISCOUNT_EN
  localparam bit COMBO_EN = 1'b1;
`else
  localparam bit COMBO_EN = 1'b0;
`endif
  localparam int CW = PRICE_W + $clog2(N_ITEMS);
  localparam int WW = CW + 8;
  localparam int VW = $clog2(VEND_CYCLES + 1);
  localparam int GW = $clog2(CHANGE_GAP + 1);
  localparam logic [WW-1:0] MAXW = WW'(MAX_CREDIT);
  localparam logic [WW-1:0] DISC = WW'(COMBO_DISCOUNT);
  state_e state_q, state_d;
  err_e err_q, err_d;
  logic [6:0] credit_q, credit_d;
  logic [N_ITEMS-1:0] mask_q, mask_d, sel_q;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [4:0] prev_q, ins, ev;
  logic [7:0] cost_bcd_q, credit_bcd_q, cost_bcd, credit_bcd, cost_sat, coin_v, credit_add, chg;
  logic [WW-1:0] sum, cost, credit_w;
  logic combo, discount_q, reject_q, reject_d, over, pulse;
  assign ins = {i_cancel, i_buy, i_quarter, i_dime, i_nickel};
  assign ev = ins & ~prev_q;
  assign coin_v = (ev[0] ? NICKEL : 8'd0) + (ev[1] ? DIME : 8'd0) + (ev[2] ? QUARTER : 8'd0);
  assign credit_add = {1'b0, credit_q} + coin_v;
  assign over = credit_add > 8'(MAX_CREDIT);
  assign credit_w = WW'(credit_q);
  assign chg = ({1'b0, credit_q} >= QUARTER) ? QUARTER : ({1'b0, credit_q} >= DIME) ? DIME : NICKEL;
  assign pulse = (state_q == ST_CHANGE) && (gap_q == '0) && (credit_q != '0);
  assign cost_sat = (cost > WW'(255)) ? 8'hFF : cost[7:0];
  // Price of the current selection, less the combo discount when enabled and matched
  always_comb begin
    sum = '0;
    for (int k = 0; k < N_ITEMS; k++)
      sum = sum + (i_sel[k] ? WW'(PRICES[k*PRICE_W +: PRICE_W]) : '0);
    combo = COMBO_EN && ((i_sel & COMBO_MASK) == COMBO_MASK);
    cost = !combo ? sum : (sum > DISC) ? sum - DISC : '0;
  end
  vend_bin2bcd u_cost_bcd   (.bin_i(cost_sat),          .bcd_o(cost_bcd));
  vend_bin2bcd u_credit_bcd (.bin_i({1'b0, credit_q}),  .bcd_o(credit_bcd));
  // Next-state, credit bookkeeping and error handling
  always_comb begin
    state_d = state_q;
    credit_d = credit_q;
    mask_d = mask_q;
    vcnt_d = vcnt_q;
    gap_d = gap_q;
    err_d = err_q;
    reject_d = coin_v != 8'd0;
    unique case (state_q)
      ST_SELECT: begin
        reject_d = (coin_v != 8'd0) && over;
        if (coin_v != 8'd0 && !over) begin
          credit_d = credit_add[6:0];
          err_d = ERR_NONE;
        end
        if (i_sel != sel_q) err_d = ERR_NONE;
        if (ev[4]) begin
          err_d = ERR_NONE;
          gap_d = '0;
          state_d = ST_CHANGE;
        end else if (ev[3]) begin
          if (cost == '0) err_d = ERR_NOSEL;
          else if (cost > MAXW) err_d = ERR_DESEL;
          else if (credit_w < cost) err_d = ERR_FUNDS;
          else begin
            err_d = ERR_NONE;
            mask_d = i_sel;
            credit_d = 7'(WW'(credit_d) - cost);
            vcnt_d = VW'(VEND_CYCLES - 1);
            state_d = ST_VEND;
          end
        end
      end
      ST_VEND: begin
        if (vcnt_q == '0) begin
          gap_d = '0;
          state_d = ST_CHANGE;
        end else vcnt_d = vcnt_q - 1'b1;
      end
      ST_CHANGE: begin
        if (credit_q == '0) state_d = ST_CLEAR;
        else if (gap_q == '0) begin
          credit_d = 7'({1'b0, credit_q} - chg);
          gap_d = GW'(CHANGE_GAP - 1);
        end else gap_d = gap_q - 1'b1;
      end
      ST_CLEAR: begin
        err_d = ERR_NONE;
        if (i_sel == '0) state_d = ST_SELECT;
      end
    endcase
  end
  // State, edge-detect history and registered display outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_SELECT;
      err_q <= ERR_NONE;
      credit_q <= '0;
      mask_q <= '0;
      sel_q <= '0;
      vcnt_q <= '0;
      gap_q <= '0;
      prev_q <= '0;
      cost_bcd_q <= '0;
      credit_bcd_q <= '0;
      discount_q <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q <= err_d;
      credit_q <= credit_d;
      mask_q <= mask_d;
      sel_q <= i_sel;
      vcnt_q <= vcnt_d;
      gap_q <= gap_d;
      prev_q <= ins;
      cost_bcd_q <= cost_bcd;
      credit_bcd_q <= credit_bcd;
      discount_q <= combo;
      reject_q <= reject_d;
    end
  end
  assign o_vend = (state_q == ST_VEND) ? mask_q : '0;
  assign o_coin_q = pulse && (chg == QUARTER);
  assign o_coin_d = pulse && (chg == DIME);
  assign o_coin_n = pulse && (chg == NICKEL);
  assign o_coin_reject = reject_q;
  assign o_error = err_q != ERR_NONE;
  assign o_err_code = err_q;
  assign o_cost_bcd = cost_bcd_q;
  assign o_credit_bcd = credit_bcd_q;
  assign o_state = state_q;
  assign o_discount = discount_q;
endmodule

// File: tb/tb_vend_ctrl_param.sv
// tb_vend_ctrl_param: directed stimulus checked per cycle against a behavioural vending model
module tb_vend_ctrl_param;
`ifdef COMBO_DISCOUNT_EN
  localparam bit COMBO = 1'b1;
`else
  localparam bit COMBO = 1'b0;
`endif
  logic clk = 0, reset = 0;
  logic i_nickel = 0, i_dime = 0, i_quarter = 0, i_buy = 0, i_cancel = 0;
  logic [3:0] i_sel = '0;
  logic [3:0] o_vend;
  logic o_coin_n, o_coin_d, o_coin_q, o_coin_reject, o_error, o_discount;
  logic [1:0] o_err_code, o_state;
  logic [7:0] o_cost_bcd, o_credit_bcd;
  int vectors = 0, miscompares = 0;
  int price[4] = '{25, 50, 65, 80};
  always #5 clk = ~clk;
  vend_ctrl_param dut (
    .clk(clk), .reset(reset), .i_nickel(i_nickel), .i_dime(i_dime), .i_quarter(i_quarter),
    .i_sel(i_sel), .i_buy(i_buy), .i_cancel(i_cancel), .o_vend(o_vend),
    .o_coin_n(o_coin_n), .o_coin_d(o_coin_d), .o_coin_q(o_coin_q), .o_coin_reject(o_coin_reject),
    .o_error(o_error), .o_err_code(o_err_code), .o_cost_bcd(o_cost_bcd), .o_credit_bcd(o_credit_bcd),
    .o_state(o_state), .o_discount(o_discount)
  );
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
    end
  endtask
  function automatic bit combo_of(input logic [3:0] s);
    return COMBO && s[0] && s[2];
  endfunction
  function automatic int cost_of(input logic [3:0] s);
    int c = 0;
    for (int k = 0; k < 4; k++) if (s[k]) c += price[k];
    if (combo_of(s)) c = (c > 10) ? c - 10 : 0;
    return c;
  endfunction
  function automatic logic [7:0] bcd(input int v);
    if (v > 99) return 8'h99;
    return {4'(v / 10), 4'(v % 10)};
  endfunction
  // model: phase 0 select, 1 vend, 2 change, 3 clear; change is a precomputed greedy coin list
  int m_state, m_credit, m_err, m_t, m_len;
  bit m_rej, m_disc;
  logic [3:0] m_mask, m_selp;
  logic [4:0] m_prev;
  logic [7:0] m_cost_bcd, m_cred_bcd;
  int coins_q[$];
  task automatic enter_change();
    int r = m_credit;
    coins_q.delete();
    while (r >= 25) begin coins_q.push_back(25); r -= 25; end
    while (r >= 10) begin coins_q.push_back(10); r -= 10; end
    while (r >= 5) begin coins_q.push_back(5); r -= 5; end
    m_len = (coins_q.size() == 0) ? 1 : 4 * (coins_q.size() - 1) + 2;
    m_t = 0;
    m_state = 2;
  endtask
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state = 0; m_credit = 0; m_err = 0; m_t = 0; m_len = 0; m_rej = 0; m_disc = 0;
      m_mask = 0; m_selp = 0; m_prev = 0; m_cost_bcd = 0; m_cred_bcd = 0; coins_q.delete();
    end else begin
      logic [4:0] ins, ev;
      int coins, c;
      ins = {i_cancel, i_buy, i_quarter, i_dime, i_nickel};
      ev = ins & ~m_prev;
      m_prev = ins;
      coins = 5 * ev[0] + 10 * ev[1] + 25 * ev[2];
      c = cost_of(i_sel);
      m_cost_bcd = bcd(c);
      m_disc = combo_of(i_sel);
      m_cred_bcd = bcd(m_credit);
      m_rej = coins > 0;
      case (m_state)
        0: begin
          m_rej = coins > 0 && m_credit + coins > 95;
          if (coins > 0 && !m_rej) begin m_credit += coins; m_err = 0; end
          if (i_sel != m_selp) m_err = 0;
          if (ev[4]) begin m_err = 0; enter_change(); end
          else if (ev[3]) begin
            if (c == 0) m_err = 1;
            else if (c > 95) m_err = 3;
            else if (m_credit - (m_rej ? 0 : coins) < c) m_err = 2;
            else begin m_err = 0; m_mask = i_sel; m_credit -= c; m_t = 0; m_state = 1; end
          end
        end
        1: begin m_t++; if (m_t == 8) enter_change(); end
        2: begin
          if (m_t % 4 == 0 && m_t / 4 < coins_q.size()) m_credit -= coins_q[m_t / 4];
          m_t++;
          if (m_t == m_len) m_state = 3;
        end
        default: begin m_err = 0; if (i_sel == 0) m_state = 0; end
      endcase
      m_selp = i_sel;
    end
  end
  // compare every output against the model, away from the active edge
  always @(negedge clk) begin
    if (reset) begin
      int ec;
      ec = (m_state == 2 && m_t % 4 == 0 && m_t / 4 < coins_q.size()) ? coins_q[m_t / 4] : 0;
      chk("state", o_state, m_state);
      chk("vend", o_vend, m_state == 1 ? m_mask : 4'd0);
      chk("coin_q", o_coin_q, ec == 25);
      chk("coin_d", o_coin_d, ec == 10);
      chk("coin_n", o_coin_n, ec == 5);
      chk("reject", o_coin_reject, m_rej);
      chk("err_code", o_err_code, m_err);
      chk("error", o_error, m_err != 0);
      chk("cost_bcd", o_cost_bcd, m_cost_bcd);
      chk("credit_bcd", o_credit_bcd, m_cred_bcd);
      chk("discount", o_discount, m_disc);
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic coin(input logic [2:0] v);
    {i_quarter, i_dime, i_nickel} = v;
    tick(1);
    {i_quarter, i_dime, i_nickel} = 3'b000;
    tick(1);
  endtask
  task automatic pulse_buy();
    i_buy = 1; tick(1); i_buy = 0; tick(1);
  endtask
  task automatic pulse_cancel();
    i_cancel = 1; tick(1); i_cancel = 0;
  endtask
  initial begin
    int nq, nd, last;
    tick(3);
    chk("rst_state", o_state, 0);
    chk("rst_credit", o_credit_bcd, 0);
    chk("rst_vend", o_vend, 0);
    reset = 1;
    tick(2);
    coin(3'b100); coin(3'b100); coin(3'b010);
    chk("credit60", o_credit_bcd, 8'h60);
    i_sel = 4'b0010; tick(2);
    i_buy = 1; tick(1); i_buy = 0;
    chk("vend_item1", o_vend, 4'b0010);
    tick(12);
    chk("clear_wait", o_state, 3);
    i_sel = 4'b0000; tick(1);
    chk("back_select", o_state, 0);
    chk("credit_zero", o_credit_bcd, 8'h00);
    coin(3'b100); coin(3'b100); coin(3'b100); coin(3'b001); coin(3'b010);
    chk("credit90", o_credit_bcd, 8'h90);
    i_quarter = 1; tick(1);
    chk("reject_pulse", o_coin_reject, 1);
    i_quarter = 0; tick(1);
    chk("credit_kept90", o_credit_bcd, 8'h90);
    pulse_cancel(); tick(20);
    coin(3'b100); coin(3'b100); coin(3'b100); coin(3'b001); coin(3'b011);
    chk("credit95", o_credit_bcd, 8'h95);
    pulse_buy();
    chk("err_nosel", o_err_code, 1);
    i_sel = 4'b1100; tick(2);
    chk("cost_sat", o_cost_bcd, 8'h99);
    pulse_buy();
    chk("err_desel", o_err_code, 3);
    i_sel = 4'b0000; tick(1);
    pulse_cancel(); tick(20);
    coin(3'b010); coin(3'b010);
    i_sel = 4'b0001; tick(2);
    pulse_buy();
    chk("err_funds", o_err_code, 2);
    chk("error_flag", o_error, 1);
    coin(3'b001);
    chk("err_cleared", o_error, 0);
    i_sel = 4'b0000; tick(1);
    pulse_cancel(); tick(4);
    coin(3'b100); coin(3'b100); coin(3'b100); coin(3'b010);
    chk("credit85", o_credit_bcd, 8'h85);
    pulse_cancel();
    nq = 0; nd = 0; last = -1;
    for (int k = 0; k < 20; k++) begin
      if (o_coin_q) nq++;
      if (o_coin_d) begin nd++; last = k; end
      tick(1);
    end
    chk("change_quarters", nq, 3);
    chk("change_dimes", nd, 1);
    chk("dime_slot", last, 12);
    chk("change_done", o_state, 0);
    coin(3'b100); coin(3'b100);
    pulse_cancel(); tick(2);
    reset = 0; #1;
    chk("arst_state", o_state, 0);
    chk("arst_credit", o_credit_bcd, 0);
    chk("arst_coin_q", o_coin_q, 0);
    chk("arst_coin_d", o_coin_d, 0);
    chk("arst_vend", o_vend, 0);
    tick(2);
    reset = 1;
    tick(2);
    coin(3'b100); coin(3'b100); coin(3'b100); coin(3'b001);
    i_sel = 4'b0101; tick(2);
    chk("combo_cost", o_cost_bcd, COMBO ? 8'h80 : 8'h90);
    chk("combo_flag", o_discount, COMBO);
    i_buy = 1; tick(1); i_buy = 0;
    chk("combo_vend", o_vend, COMBO ? 4'b0101 : 4'b0000);
    chk("combo_err", o_err_code, COMBO ? 0 : 2);
    i_sel = 4'b0000;
    tick(12);
    pulse_cancel(); tick(24);
    chk("final_state", o_state, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
